// File: rtl/jt10_burst_seq_pkg.sv
// Shared ADPCM burst definitions: sequencer state encoding and channel-count default.
package jt10_adpcm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int ADPCMA_NCH = 6;

endpackage

// File: rtl/jt10_burst_seq_if.sv
// Burst-sequencer bus: period/enable controls, gated pulses in, channel strobes and status out.
interface jt10_burst_seq_if #(
   parameter int CW = 3
);

   logic          cen;
   logic          start_cen;
   logic          en;
   logic          clr_err;
   logic          cen_in;
   logic          start;
   logic          busy;
   logic [CW-1:0] chan;
   logic          step;
   logic          first;
   logic          last;
   logic          done;
   logic          err_short;
   logic          err_overrun;

   modport master (
      output cen, start_cen, en, clr_err, cen_in,
      input  start, busy, chan, step, first, last, done, err_short, err_overrun
   );

   modport slave (
      input  cen, start_cen, en, clr_err, cen_in,
      output start, busy, chan, step, first, last, done, err_short, err_overrun
   );

endinterface

// File: rtl/jt10_burst_seq_tmo.sv
// Idle-pulse timeout counter: clear wins, counts on inc, expires on the TMO-th inc.
module jt10_burst_tmo #(
   parameter int TMO = 12,
   parameter int TW  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expire
);

   logic [TW-1:0] r_cnt;

   assign o_expire = i_inc && (r_cnt == TW'(TMO - 1));

   // NOTE: sequential state uses <= so every register here samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || i_clr || o_expire) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + TW'(1);
      end
   end

endmodule

// File: rtl/jt10_burst_seq.sv
// ADPCM burst sequencer: requests a burst each sample period, steps channels on gated
// pulses, and reports burst end, short bursts (timeout) and sticky period overruns.
module jt10_burst_seq
   import jt10_adpcm_pkg::*;
#(
   parameter int NCH = ADPCMA_NCH,
   parameter int CW  = 3,
   parameter int TMO = 12,
   parameter int TW  = 4
) (
   input logic              clk,
   input logic              rst,
   jt10_burst_seq_if.slave  bus
);

   state_t        r_state, w_state_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic          r_short, w_short_next;
   logic          r_overrun;

   logic w_p, w_g, w_run, w_gate, w_last_cnt, w_tmo_inc, w_tmo_clr, w_expire;

   assign w_p        = bus.cen & bus.start_cen;
   assign w_g        = bus.cen & bus.cen_in;
   assign w_run      = (r_state == ST_RUN);
   assign w_gate     = w_run & w_g;
   assign w_last_cnt = (r_cnt == CW'(NCH - 1));
   assign w_tmo_inc  = w_run & bus.cen & ~bus.cen_in;
   assign w_tmo_clr  = ~w_run | w_g;

   jt10_burst_tmo #(.TMO(TMO), .TW(TW)) u_tmo (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_tmo_clr),
      .i_inc    (w_tmo_inc),
      .o_expire (w_expire)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_short_next = 1'b0;
      case (r_state)
         ST_IDLE: if (bus.en && w_p) w_state_next = ST_ARM;
         ST_ARM: begin
            if (!bus.en) begin
               w_state_next = ST_IDLE;
            end else if (w_p) begin
               w_state_next = ST_RUN;
               w_cnt_next   = '0;
            end
         end
         ST_RUN: begin
            if (w_gate) begin
               if (w_last_cnt) begin
                  w_state_next = ST_DONE;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + CW'(1);
               end
            end else if (w_expire) begin
               // Short burst: channel index returns to 0 so the next burst starts clean.
               w_state_next = ST_DONE;
               w_cnt_next   = '0;
               w_short_next = 1'b1;
            end
         end
         ST_DONE: w_state_next = (bus.en && w_p) ? ST_ARM : ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_short   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_short <= w_short_next;
         // A new period during RUN is an overrun; setting beats a same-cycle clear.
         if (w_run && w_p)     r_overrun <= 1'b1;
         else if (bus.clr_err) r_overrun <= 1'b0;
      end
   end

   assign bus.start       = (r_state == ST_ARM);
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.chan        = r_cnt;
   assign bus.step        = w_gate;
   assign bus.first       = w_gate & (r_cnt == '0);
   assign bus.last        = w_gate & w_last_cnt;
   assign bus.done        = (r_state == ST_DONE);
   assign bus.err_short   = (r_state == ST_DONE) & r_short;
   assign bus.err_overrun = r_overrun;

endmodule
